// File: rtl/btn_conditioner_pkg.sv
// Shared game package: repeat-FSM state encoding, default button timing constants
// and the counter-width helper used by the button conditioner.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DLY      = 2'd1,
        RPT      = 2'd2,
        WAIT_REL = 2'd3
    } rpt_state_t;

    localparam int DEF_DEBOUNCE_CYC = 250000;
    localparam int DEF_REPEAT_DLY   = 0;
    localparam int DEF_REPEAT_PER   = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One spare bit above the largest count so no counter can ever wrap.
    function automatic int cnt_width(input int dc, input int rd, input int rp);
        return $clog2(max3(dc, rd, rp)) + 1;
    endfunction

endpackage

// File: rtl/btn_conditioner_debounce.sv
// One button: 2-FF synchroniser, debounce counter and auto-repeat FSM.
// 'level' is the debounced value being committed this cycle, so 'pulse' lines up with it.
module btn_debounce
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PER - 1);
    localparam bit               REPEAT_EN = (REPEAT_DLY > 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             sync1, sync2;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] db_cnt, db_cnt_d;
    rpt_state_t       state, state_d;
    logic [CNT_W-1:0] rpt_cnt, rpt_cnt_d;
    logic             rise, fall, dly_hit, rpt_hit;

    // The level flips on the DEBOUNCE_CYC-th consecutive disagreeing edge.
    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        if (sync2 != lvl_q) begin
            if (db_cnt == DB_LAST) begin
                lvl_d = ~lvl_q;
            end else begin
                db_cnt_d = sat_inc(db_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            lvl_q  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            lvl_q  <= lvl_d;
            db_cnt <= db_cnt_d;
        end
    end

    assign level   = lvl_d;
    assign rise    = lvl_d & ~lvl_q;
    assign fall    = lvl_q & ~lvl_d;
    assign dly_hit = (rpt_cnt == RD_LAST);
    assign rpt_hit = (rpt_cnt == RP_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rpt_cnt <= '0;
        end else begin
            state   <= state_d;
            rpt_cnt <= rpt_cnt_d;
        end
    end

    // A release always wins over enable and repeat timing.
    always_comb begin
        state_d   = state;
        rpt_cnt_d = '0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_d = (en && REPEAT_EN) ? DLY : WAIT_REL;
                end
            end
            DLY: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (!en) begin
                    state_d = WAIT_REL;
                end else if (dly_hit) begin
                    state_d = RPT;
                end else begin
                    rpt_cnt_d = sat_inc(rpt_cnt);
                end
            end
            RPT: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (!en) begin
                    state_d = WAIT_REL;
                end else if (!rpt_hit) begin
                    rpt_cnt_d = sat_inc(rpt_cnt);
                end
            end
            WAIT_REL: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pulse = 1'b0;
        case (state)
            IDLE:    pulse = rise & en;
            DLY:     pulse = ~fall & en & dly_hit;
            RPT:     pulse = ~fall & en & rpt_hit;
            default: pulse = 1'b0;
        endcase
    end

endmodule

// File: rtl/btn_conditioner.sv
// Left/right push-button conditioner feeding player_ctrl: two btn_debounce
// channels, a mutual mask so opposing moves never issue together, and output registers.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic btn_l_raw,
    input  logic btn_r_raw,
    output logic btn_l,
    output logic btn_r,
    output logic btn_l_level,
    output logic btn_r_level
);

    logic level_l, level_r, pulse_l, pulse_r;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DLY   (REPEAT_DLY),
        .REPEAT_PER   (REPEAT_PER)
    ) u_left (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .raw   (btn_l_raw),
        .level (level_l),
        .pulse (pulse_l)
    );

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DLY   (REPEAT_DLY),
        .REPEAT_PER   (REPEAT_PER)
    ) u_right (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .raw   (btn_r_raw),
        .level (level_r),
        .pulse (pulse_r)
    );

    // Masking uses the levels committed this cycle, so a simultaneous press of both is suppressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_l       <= 1'b0;
            btn_r       <= 1'b0;
            btn_l_level <= 1'b0;
            btn_r_level <= 1'b0;
        end else begin
            btn_l       <= pulse_l & en & ~level_r;
            btn_r       <= pulse_r & en & ~level_l;
            btn_l_level <= level_l;
            btn_r_level <= level_r;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=5.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_btn_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b1;
    logic btn_l_raw = 1'b0;
    logic btn_r_raw = 1'b0;
    logic btn_l, btn_r, btn_l_level, btn_r_level;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYC (4),
        .REPEAT_DLY   (10),
        .REPEAT_PER   (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .btn_l_raw   (btn_l_raw),
        .btn_r_raw   (btn_r_raw),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .btn_l_level (btn_l_level),
        .btn_r_level (btn_r_level)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({btn_l, btn_r, btn_l_level, btn_r_level} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000", {btn_l, btn_r, btn_l_level, btn_r_level});
        end
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_bounce();
        logic want;
        for (int p = 0; p < 4; p++) begin
            btn_l_raw = (p % 2 == 0);
            repeat (2) begin
                tick();
                tests_run++;
                if ({btn_l, btn_l_level} !== 2'b00) begin
                    tests_failed++;
                    $display("[TB] FAIL bounce_quiet p=%0d: got %b expected 00", p, {btn_l, btn_l_level});
                end
            end
        end
        btn_l_raw = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            want = (t == 6);
            tests_run++;
            if (btn_l !== want || btn_r !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bounce_pulse t=%0d: got l=%b r=%b expected l=%b r=0", t, btn_l, btn_r, want);
            end
        end
        tests_run++;
        if (btn_l_level !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bounce_level: got %b expected 1", btn_l_level);
        end
        btn_l_raw = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            tests_run++;
            if (btn_l !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bounce_release t=%0d: got %b expected 0", t, btn_l);
            end
        end
        tests_run++;
        if (btn_l_level !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bounce_release_level: got %b expected 0", btn_l_level);
        end
    endtask

    task automatic test_glitch();
        btn_r_raw = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            tick();
            if (t == 3) btn_r_raw = 1'b0;
            tests_run++;
            if ({btn_r, btn_r_level} !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL glitch t=%0d: got %b expected 00", t, {btn_r, btn_r_level});
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic want;
        int   pulses;
        pulses = 0;
        btn_l_raw = 1'b1;
        for (int t = 1; t <= 52; t++) begin
            tick();
            want = (t == 6) || (t >= 16 && t <= 41 && (t - 16) % 5 == 0);
            if (btn_l === 1'b1) pulses++;
            tests_run++;
            if (btn_l !== want) begin
                tests_failed++;
                $display("[TB] FAIL repeat_pulse t=%0d: got %b expected %b", t, btn_l, want);
            end
            if (t == 45 || t == 46) begin
                tests_run++;
                if (btn_l_level !== (t == 45)) begin
                    tests_failed++;
                    $display("[TB] FAIL repeat_level t=%0d: got %b expected %b", t, btn_l_level, (t == 45));
                end
            end
            if (t == 40) btn_l_raw = 1'b0;
        end
        tests_run++;
        if (pulses != 7) begin
            tests_failed++;
            $display("[TB] FAIL repeat_count: got %0d expected 7", pulses);
        end
    endtask

    task automatic test_both_held();
        logic want;
        btn_l_raw = 1'b1;
        btn_r_raw = 1'b1;
        for (int t = 1; t <= 45; t++) begin
            tick();
            want = (t == 31) || (t == 36);
            tests_run++;
            if (btn_l !== want || btn_r !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL both_pulses t=%0d: got l=%b r=%b expected l=%b r=0", t, btn_l, btn_r, want);
            end
            if (t == 6) begin
                tests_run++;
                if ({btn_l_level, btn_r_level} !== 2'b11) begin
                    tests_failed++;
                    $display("[TB] FAIL both_levels: got %b expected 11", {btn_l_level, btn_r_level});
                end
            end
            if (t == 27 || t == 28) begin
                tests_run++;
                if (btn_r_level !== (t == 27)) begin
                    tests_failed++;
                    $display("[TB] FAIL both_r_release t=%0d: got %b expected %b", t, btn_r_level, (t == 27));
                end
            end
            if (t == 22) btn_r_raw = 1'b0;
            if (t == 33) btn_l_raw = 1'b0;
        end
        tests_run++;
        if (btn_l_level !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL both_l_release: got %b expected 0", btn_l_level);
        end
    endtask

    task automatic test_enable();
        logic want;
        en = 1'b0;
        btn_l_raw = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            tests_run++;
            if (btn_l !== 1'b0 || (t == 6 && btn_l_level !== 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL en_low t=%0d: got l=%b level=%b expected l=0", t, btn_l, btn_l_level);
            end
        end
        en = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            tests_run++;
            if (btn_l !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL en_rise_held t=%0d: got %b expected 0", t, btn_l);
            end
        end
        btn_l_raw = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            tests_run++;
            if (btn_l !== 1'b0 || (t == 6 && btn_l_level !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL en_release t=%0d: got l=%b level=%b expected l=0", t, btn_l, btn_l_level);
            end
        end
        btn_l_raw = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            want = (t == 6);
            tests_run++;
            if (btn_l !== want) begin
                tests_failed++;
                $display("[TB] FAIL en_repress t=%0d: got %b expected %b", t, btn_l, want);
            end
        end
        btn_l_raw = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            tests_run++;
            if (btn_l !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL en_final_release t=%0d: got %b expected 0", t, btn_l);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic want;
        btn_l_raw = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            tick();
            want = (t == 6) || (t == 16) || (t == 21);
            tests_run++;
            if (btn_l !== want) begin
                tests_failed++;
                $display("[TB] FAIL midreset_pre t=%0d: got %b expected %b", t, btn_l, want);
            end
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({btn_l, btn_r, btn_l_level, btn_r_level} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async: got %b expected 0000", {btn_l, btn_r, btn_l_level, btn_r_level});
        end
        tick();
        tick();
        tests_run++;
        if ({btn_l, btn_l_level} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL midreset_held: got %b expected 00", {btn_l, btn_l_level});
        end
        reset = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            want = (t == 6);
            tests_run++;
            if (btn_l !== want || (t == 6 && btn_l_level !== 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL midreset_repress t=%0d: got l=%b level=%b expected l=%b", t, btn_l, btn_l_level, want);
            end
        end
        btn_l_raw = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            tests_run++;
            if (btn_l !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midreset_release t=%0d: got %b expected 0", t, btn_l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_both_held();
        test_enable();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
